adder_response_checker: RTL and testbench

- Sequential self-checking monitor on the result side of the WIDTH-bit ripple-carry adder.
- Each handshaken beat captures operands a/b and the adder result s/co, then compares {co,s} against the golden sum a+b.
- Counts vectors and mismatches, records the first failing vector, and reports pass/fail when the expected vector count is reached.
- Sits beside the adder under test, in place of a software $monitor/$display check.

---
 rtl/adder_response_checker.sv | 98 +++++++++
 tb/tb_adder_response_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adder_response_checker.sv
// adder_response_checker: scores a WIDTH-bit adder's {co,s} against a+b over EXPECT_N handshaken beats.
// Define CHECKER_STOP_ON_FAIL_EN to end the run at the first mismatch.
module adder_response_checker #(
  parameter int WIDTH    = 3,
  parameter int EXPECT_N = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_s,
  output logic             fail_co,
  output logic             fail_seen
);
`ifdef CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t state;
  logic [WIDTH:0] expected;
  logic accept, mismatch, stop;
  logic [CNT_W-1:0] err_next;
  always_comb begin
    expected = {1'b0, a} + {1'b0, b};
    accept   = in_valid && in_ready;
    mismatch = {co, s} != expected;
    err_next = (mismatch && err_count != '1) ? err_count + 1'b1 : err_count;
    stop     = (vec_count == CNT_W'(EXPECT_N - 1)) || (STOP_ON_FAIL && mismatch);
  end
  // in_ready mirrors state==CHECK, so accept is never true outside CHECK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_s    <= '0;
      fail_co   <= 1'b0;
      fail_seen <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state     <= CHECK;
          in_ready  <= 1'b1;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          vec_count <= '0;
          err_count <= '0;
          fail_a    <= '0;
          fail_b    <= '0;
          fail_s    <= '0;
          fail_co   <= 1'b0;
          fail_seen <= 1'b0;
        end
        CHECK: if (accept) begin
          vec_count <= vec_count + 1'b1;
          err_count <= err_next;
          if (mismatch && !fail_seen) begin
            fail_a    <= a;
            fail_b    <= b;
            fail_s    <= s;
            fail_co   <= co;
            fail_seen <= 1'b1;
          end
          if (stop) begin
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= err_next == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_response_checker.sv
// tb_adder_response_checker: directed vectors against the checker, plus a small CNT_W=3 instance for saturation.
module tb_adder_response_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, start2 = 1'b0, valid2 = 1'b0;
  logic [2:0] a = '0, b = '0, s = '0;
  logic co = 1'b0;
  logic in_ready, busy, done, pass, fail_co, fail_seen;
  logic [7:0] vec_count, err_count;
  logic [2:0] fail_a, fail_b, fail_s;
  logic ready2, busy2, done2, pass2, fco2, fseen2;
  logic [2:0] vec2, err2, fa2, fb2, fs2;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  adder_response_checker #(.WIDTH(3), .EXPECT_N(64), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .co(co), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b),
    .fail_s(fail_s), .fail_co(fail_co), .fail_seen(fail_seen));

  adder_response_checker #(.WIDTH(3), .EXPECT_N(7), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(valid2), .in_ready(ready2),
    .a(a), .b(b), .s(s), .co(co), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec2), .err_count(err2), .fail_a(fa2), .fail_b(fb2),
    .fail_s(fs2), .fail_co(fco2), .fail_seen(fseen2));

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // apply one cycle of stimulus; bad forces co=0 like a broken carry chain
  task automatic drive(input int ai, input int bi, input bit bad, input bit v);
    logic [3:0] sum;
    sum = 4'(ai) + 4'(bi);
    a = 3'(ai);
    b = 3'(bi);
    s = sum[2:0];
    co = bad ? 1'b0 : sum[3];
    in_valid = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep(input bit bad);
    for (int i = 0; i < 64; i++) drive(i / 8, i % 8, bad, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst vec", vec_count, 0);
    check("rst err", err_count, 0);
    check("rst fail_seen", fail_seen, 0);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) drive(3, 4, 1'b0, 1'b1);
    check("idle no accept", vec_count, 0);
    check("idle in_ready", in_ready, 0);
    pulse_start();
    check("start busy", busy, 1);
    check("start in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) drive(i, 2, 1'b0, 1'b1);
    check("5 beats", vec_count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst in_ready", in_ready, 0);
    check("async rst vec", vec_count, 0);
    check("async rst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    drive(1, 1, 1'b0, 1'b1);
    check("toggle c1", vec_count, 1);
    drive(1, 1, 1'b0, 1'b0);
    check("toggle c2", vec_count, 1);
    drive(1, 1, 1'b0, 1'b0);
    check("toggle c3", vec_count, 1);
    drive(1, 1, 1'b0, 1'b1);
    check("toggle c4", vec_count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    sweep(1'b0);
    check("good done", done, 1);
    check("good pass", pass, 1);
    check("good busy", busy, 0);
    check("good vec", vec_count, 64);
    check("good err", err_count, 0);
    check("good fail_seen", fail_seen, 0);
    repeat (2) drive(7, 7, 1'b1, 1'b1);
    check("done no accept", vec_count, 64);
    check("done err held", err_count, 0);
    start = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    check("restart vec", vec_count, 0);
    check("restart done", done, 0);
    check("restart busy", busy, 1);
    sweep(1'b1);
    check("bad done", done, 1);
    check("bad pass", pass, 0);
    check("bad fail_seen", fail_seen, 1);
    check("bad fail_a", fail_a, 1);
    check("bad fail_b", fail_b, 7);
    check("bad fail_s", fail_s, 0);
    check("bad fail_co", fail_co, 0);
`ifdef CHECKER_STOP_ON_FAIL_EN
    check("bad err", err_count, 1);
    check("bad vec", vec_count, 16);
`else
    check("bad err", err_count, 28);
    check("bad vec", vec_count, 64);
`endif
    pulse_start();
    for (int i = 0; i < 10; i++) drive(i % 8, 5, 1'b0, 1'b1);
    check("mid vec", vec_count, 10);
    pulse_start();
    check("mid start ignored vec", vec_count, 10);
    check("mid start busy", busy, 1);
    for (int i = 0; i < 54; i++) drive(6, i % 8, 1'b0, 1'b1);
    check("mid run done", done, 1);
    check("mid run vec", vec_count, 64);
    check("mid run pass", pass, 1);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("sat busy", busy2, 1);
    for (int i = 0; i < 9; i++) begin
      valid2 = 1'b1;
      drive(5, 6, 1'b1, 1'b0);
    end
    valid2 = 1'b0;
    check("sat done", done2, 1);
    check("sat pass", pass2, 0);
    check("sat fail_a", fa2, 5);
    check("sat fail_s", fs2, 3);
`ifdef CHECKER_STOP_ON_FAIL_EN
    check("sat err", err2, 1);
    check("sat vec", vec2, 1);
`else
    check("sat err", err2, 7);
    check("sat vec", vec2, 7);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
